// File: rtl/dp_pkg.sv
// Shared opcode encodings, flag bit positions and per-op decode helpers for the
// two-stage register-file/ALU datapath.
package dp_pkg;

  localparam int FLAGS_W = 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_CMP  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_LSH  = 4'd8;

  // flags vector is {Z,C,F,L,N}
  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_N = 0;

  function automatic logic [FLAGS_W-1:0] flag_mask(input logic [3:0] op);
    logic [FLAGS_W-1:0] m;
    m = '0;
    case (op)
      OP_ADD, OP_ADDC, OP_SUB: begin
        m[FLAG_Z] = 1'b1;
        m[FLAG_C] = 1'b1;
        m[FLAG_F] = 1'b1;
        m[FLAG_N] = 1'b1;
      end
      OP_CMP: begin
        m[FLAG_Z] = 1'b1;
        m[FLAG_L] = 1'b1;
        m[FLAG_N] = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LSH: begin
        m[FLAG_Z] = 1'b1;
        m[FLAG_N] = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic op_writes_reg(input logic [3:0] op);
    return (op <= OP_LSH) && (op != OP_CMP);
  endfunction

  function automatic logic op_reads_a(input logic [3:0] op);
    return (op <= OP_LSH) && (op != OP_MOV);
  endfunction

  // register B is read only when the immediate is not substituted
  function automatic logic op_reads_b(input logic [3:0] op);
    return op <= OP_LSH;
  endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU for the execute stage: (op, a, b, cin) -> result, new flags
// and the mask of flags this op is allowed to update.
module dp_alu
  import dp_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]         i_op,
  input  logic [DATA_W-1:0]  i_a,
  input  logic [DATA_W-1:0]  i_b,
  input  logic               i_cin,
  output logic [DATA_W-1:0]  o_result,
  output logic [FLAGS_W-1:0] o_flags,
  output logic [FLAGS_W-1:0] o_mask
);

  localparam int MSB = DATA_W - 1;
  localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic              w_cin_eff;
  logic              w_add_ovf;
  logic              w_sub_ovf;
  logic              w_shift_neg;
  logic [DATA_W-1:0] w_shift_mag;
  logic [DATA_W-1:0] w_shift_res;

  assign w_cin_eff = (i_op == OP_ADDC) && i_cin;
  assign w_sum     = {1'b0, i_a} + {1'b0, i_b} + {{DATA_W{1'b0}}, w_cin_eff};
  assign w_diff    = {1'b0, i_a} - {1'b0, i_b};
  assign w_add_ovf = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
  assign w_sub_ovf = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);

  // B is a signed shift count: positive shifts left, negative shifts right logically
  assign w_shift_neg = i_b[MSB];
  assign w_shift_mag = w_shift_neg ? -i_b : i_b;

  always_comb begin
    w_shift_res = '0;
    if (w_shift_mag >= SHIFT_LIM) begin
      w_shift_res = '0;
    end else if (w_shift_neg) begin
      w_shift_res = i_a >> w_shift_mag;
    end else begin
      w_shift_res = i_a << w_shift_mag;
    end
  end

  always_comb begin
    o_result = '0;
    o_flags  = '0;
    case (i_op)
      OP_ADD, OP_ADDC: begin
        o_result        = w_sum[DATA_W-1:0];
        o_flags[FLAG_C] = w_sum[DATA_W];
        o_flags[FLAG_F] = w_add_ovf;
      end
      OP_SUB: begin
        o_result        = w_diff[DATA_W-1:0];
        o_flags[FLAG_C] = w_diff[DATA_W];
        o_flags[FLAG_F] = w_sub_ovf;
      end
      // CMP reports the difference on res_data but never writes it back
      OP_CMP: begin
        o_result        = w_diff[DATA_W-1:0];
        o_flags[FLAG_L] = w_diff[DATA_W];
      end
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_MOV: o_result = i_b;
      OP_LSH: o_result = w_shift_res;
      default: o_result = '0;
    endcase
    if (i_op == OP_CMP) begin
      o_flags[FLAG_Z] = (i_a == i_b);
      o_flags[FLAG_N] = ($signed(i_a) < $signed(i_b));
    end else begin
      o_flags[FLAG_Z] = (o_result == '0);
      o_flags[FLAG_N] = o_result[MSB];
    end
  end

  assign o_mask = flag_mask(i_op);

endmodule

// File: rtl/pipelined_datapath.sv
// Two-stage register-file/ALU datapath: read/issue, then execute/writeback.
// Define DP_FWD_EN to bypass the EX result and carry instead of stalling on hazards.
module pipelined_datapath
  import dp_pkg::*;
#(
  parameter int  DATA_W = 16,
  parameter int  NREGS  = 16,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [REG_AW-1:0]  in_dst,
  input  logic [REG_AW-1:0]  in_srca,
  input  logic [REG_AW-1:0]  in_srcb,
  input  logic               in_use_imm,
  input  logic [DATA_W-1:0]  in_imm,
  output logic               res_valid,
  output logic [DATA_W-1:0]  res_data,
  output logic [REG_AW-1:0]  res_dst,
  output logic [FLAGS_W-1:0] flags,
  input  logic [REG_AW-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
);

  logic [DATA_W-1:0]  r_regs [NREGS];
  logic [FLAGS_W-1:0] r_flags;

  logic               r_ex_valid;
  logic [3:0]         r_ex_op;
  logic [REG_AW-1:0]  r_ex_dst;
  logic [DATA_W-1:0]  r_ex_a;
  logic [DATA_W-1:0]  r_ex_b;
  logic               r_ex_cin;

  logic               r_res_valid;
  logic [DATA_W-1:0]  r_res_data;
  logic [REG_AW-1:0]  r_res_dst;

  logic [DATA_W-1:0]  w_alu_result;
  logic [FLAGS_W-1:0] w_alu_flags;
  logic [FLAGS_W-1:0] w_alu_mask;

  logic               w_ex_wr;
  logic               w_ex_updc;
  logic               w_hit_a;
  logic               w_hit_b;
  logic               w_hit_c;
  logic [DATA_W-1:0]  w_reg_a;
  logic [DATA_W-1:0]  w_reg_b;
  logic [DATA_W-1:0]  w_opa;
  logic [DATA_W-1:0]  w_opb;
  logic               w_cin;
  logic               w_fire;

  dp_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op     (r_ex_op),
    .i_a      (r_ex_a),
    .i_b      (r_ex_b),
    .i_cin    (r_ex_cin),
    .o_result (w_alu_result),
    .o_flags  (w_alu_flags),
    .o_mask   (w_alu_mask)
  );

  // Hazard: the instruction now in EX produces a register or carry that the
  // incoming instruction consumes at issue.
  assign w_ex_wr   = r_ex_valid && op_writes_reg(r_ex_op);
  assign w_ex_updc = r_ex_valid && w_alu_mask[FLAG_C];
  assign w_hit_a   = w_ex_wr && op_reads_a(in_op) && (r_ex_dst == in_srca);
  assign w_hit_b   = w_ex_wr && op_reads_b(in_op) && !in_use_imm && (r_ex_dst == in_srcb);
  assign w_hit_c   = w_ex_updc && (in_op == OP_ADDC);

  assign w_reg_a = r_regs[in_srca];
  assign w_reg_b = r_regs[in_srcb];

`ifdef DP_FWD_EN
  assign w_opa    = w_hit_a ? w_alu_result : w_reg_a;
  assign w_opb    = in_use_imm ? in_imm : (w_hit_b ? w_alu_result : w_reg_b);
  assign w_cin    = w_hit_c ? w_alu_flags[FLAG_C] : r_flags[FLAG_C];
  assign in_ready = reset;
`else
  // A one-cycle bubble lets the EX result land before the operands are read.
  assign w_opa    = w_reg_a;
  assign w_opb    = in_use_imm ? in_imm : w_reg_b;
  assign w_cin    = r_flags[FLAG_C];
  assign in_ready = reset && !(w_hit_a || w_hit_b || w_hit_c);
`endif

  // Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
  // in_valid/payload must be stable while waiting, and results retire exactly one
  // edge later as a single-cycle res_valid pulse with no backpressure.
  assign w_fire = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_dst   <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_cin   <= 1'b0;
    end else begin
      r_ex_valid <= w_fire;
      if (w_fire) begin
        r_ex_op  <= in_op;
        r_ex_dst <= in_dst;
        r_ex_a   <= w_opa;
        r_ex_b   <= w_opb;
        r_ex_cin <= w_cin;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_flags     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_dst   <= '0;
    end else begin
      r_res_valid <= r_ex_valid;
      if (r_ex_valid) begin
        if (op_writes_reg(r_ex_op)) begin
          r_regs[r_ex_dst] <= w_alu_result;
        end
        r_flags    <= (r_flags & ~w_alu_mask) | (w_alu_flags & w_alu_mask);
        r_res_data <= w_alu_result;
        r_res_dst  <= r_ex_dst;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_dst   = r_res_dst;
  assign flags     = r_flags;
  assign dbg_data  = r_regs[dbg_sel];

endmodule

// File: tb/tb_pipelined_datapath.sv
// Self-checking bench for pipelined_datapath: directed scenarios with literal
// expectations plus randomized traffic against an architectural integer model.
module tb_pipelined_datapath;

  localparam int DW = 16;
  localparam int NR = 16;
  localparam int AW = 4;
`ifdef DP_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int EXP_ST = FWD ? 0 : 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [AW-1:0] in_dst;
  logic [AW-1:0] in_srca;
  logic [AW-1:0] in_srcb;
  logic          in_use_imm;
  logic [DW-1:0] in_imm;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [AW-1:0] res_dst;
  logic [4:0]    flags;
  logic [AW-1:0] dbg_sel;
  logic [DW-1:0] dbg_data;

  pipelined_datapath #(.DATA_W(DW), .NREGS(NR)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_dst(in_dst), .in_srca(in_srca), .in_srcb(in_srcb),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .res_valid(res_valid),
    .res_data(res_data), .res_dst(res_dst), .flags(flags),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int         n_total = 0;
  int         n_bad   = 0;
  bit         chk_en  = 1'b0;
  int         m_regs [NR];
  logic [4:0] m_flags;
  logic [4:0] cur_flags;
  // entry = {accept cycle[31:0], flags[4:0], dst[3:0], data[15:0]}
  logic [56:0] exp_q[$];
  int         last_acc_cyc = -10;
  bit         last_wr;
  bit         last_updc;
  int         last_dst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 0;
    m_flags      = 5'd0;
    cur_flags    = 5'd0;
    exp_q.delete();
    last_acc_cyc = -10;
  endtask

  // Architectural effect of one instruction, applied in program order at accept.
  task automatic model_accept(input logic [3:0] op, input int dst, input int sa, input int sb,
                              input logic ui, input logic [15:0] imm);
    int a, b, r, s, ss, ci;
    bit wr;
    logic [4:0] f;
    a  = m_regs[sa];
    b  = ui ? int'(imm) : m_regs[sb];
    f  = m_flags;
    r  = 0;
    wr = 1'b0;
    ci = (op == 4'd1 && m_flags[3]) ? 1 : 0;
    case (int'(op))
      0, 1: begin
        s = a + b + ci; r = s & 65535; f[3] = (s > 65535);
        ss = sx(a) + sx(b) + ci; f[2] = (ss > 32767) || (ss < -32768); wr = 1'b1;
      end
      2: begin
        r = (a - b) & 65535; f[3] = (a < b);
        ss = sx(a) - sx(b); f[2] = (ss > 32767) || (ss < -32768); wr = 1'b1;
      end
      3: begin
        r = (a - b) & 65535; f[4] = (a == b); f[1] = (a < b); f[0] = (sx(a) < sx(b));
      end
      4: begin r = a & b; wr = 1'b1; end
      5: begin r = a | b; wr = 1'b1; end
      6: begin r = a ^ b; wr = 1'b1; end
      7: begin r = b;     wr = 1'b1; end
      8: begin
        if (sx(b) >= 0) r = (sx(b) >= 16) ? 0 : ((a << sx(b)) & 65535);
        else            r = (-sx(b) >= 16) ? 0 : (a >> (-sx(b)));
        wr = 1'b1;
      end
      default: r = 0;
    endcase
    if (wr) begin
      f[4] = (r == 0);
      f[0] = (r >= 32768);
      m_regs[dst] = r;
    end
    m_flags = f;
    exp_q.push_back({32'(cyc), f, 4'(dst), 16'(r)});
    last_acc_cyc = cyc;
    last_wr      = wr;
    last_dst     = dst;
    last_updc    = (op <= 4'd2);
  endtask

  // Without bypassing, an instruction reading what the previous-cycle instruction produces must wait.
  function automatic bit exp_ready(input logic [3:0] op, input int sa, input int sb, input logic ui);
    bit busy, rda, rdb, haz;
    busy = (last_acc_cyc == cyc - 1);
    rda  = (op <= 4'd8) && (op != 4'd7);
    rdb  = (op <= 4'd8) && !ui;
    haz  = busy && ((last_wr && ((rda && sa == last_dst) || (rdb && sb == last_dst)))
                    || (last_updc && op == 4'd1));
    return FWD || !haz;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [56:0] e;
    bit exp_rv;
    if (chk_en) begin
      exp_rv = (exp_q.size() > 0) && (int'(exp_q[0][56:25]) == cyc - 2);
      check("res_valid", 32'(res_valid), 32'(exp_rv));
      if (exp_rv) begin
        e = exp_q.pop_front();
        if (res_valid) begin
          check("res_data", 32'(res_data), 32'(e[15:0]));
          check("res_dst", 32'(res_dst), 32'(e[19:16]));
        end
        cur_flags = e[24:20];
      end
      check("flags", 32'(flags), 32'(cur_flags));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] op, input int dst, input int sa, input int sb,
                       input logic ui, input logic [15:0] imm, output int stalls);
    bit done;
    done       = 1'b0;
    stalls     = 0;
    in_valid   = 1'b1;
    in_op      = op;
    in_dst     = 4'(dst);
    in_srca    = 4'(sa);
    in_srcb    = 4'(sb);
    in_use_imm = ui;
    in_imm     = imm;
    for (int k = 0; k < 4 && !done; k++) begin
      #1;
      check("in_ready", 32'(in_ready), 32'(exp_ready(op, sa, sb, ui)));
      if (in_ready) begin
        model_accept(op, dst, sa, sb, ui, imm);
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!done) begin
      n_total++;
      n_bad++;
      $display("FAIL issue_timeout: got no accept expected accept within 4 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic peek(input string name, input int r, input logic [15:0] exp);
    dbg_sel = 4'(r);
    #1;
    check(name, 32'(dbg_data), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int st, rmax, sa, sb, dst;
    logic [3:0] op;
    logic [15:0] imm;
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_dst = '0; in_srca = '0;
    in_srcb = '0; in_use_imm = 1'b0; in_imm = '0; dbg_sel = '0;
    model_reset();
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;

    // reset state
    for (int r = 0; r < NR; r++) peek("reset_reg", r, 16'h0000);
    check("reset_flags", 32'(flags), 32'd0);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("ready_after_release", 32'(in_ready), 32'd1);
    @(negedge clk);

    // dependent ADD chain; r1 still old while ADD sits in EX
    issue(4'd0, 1, 0, 0, 1'b1, 16'd5, st);
    peek("t2_r1_before_wb", 1, 16'h0000);
    issue(4'd0, 2, 1, 1, 1'b0, 16'd0, st);
    check("t2_stalls", 32'(st), 32'(EXP_ST));
    idle(3);
    peek("t2_r1", 1, 16'd5);
    peek("t2_r2", 2, 16'd10);

    // carry out and carry in
    issue(4'd7, 1, 0, 0, 1'b1, 16'hFFFF, st);
    issue(4'd0, 2, 1, 0, 1'b1, 16'h0001, st);
    issue(4'd1, 3, 0, 0, 1'b0, 16'h0000, st);
    check("t3_add_flags", 32'(flags), 32'b11000);
    idle(3);
    peek("t3_r2", 2, 16'h0000);
    peek("t3_r3", 3, 16'h0001);
    check("t3_addc_flags", 32'(flags), 32'b00000);

    // signed overflow on SUB
    issue(4'd7, 1, 0, 0, 1'b1, 16'h8000, st);
    issue(4'd2, 2, 1, 0, 1'b1, 16'h0001, st);
    idle(3);
    peek("t4_r2", 2, 16'h7FFF);
    check("t4_flags", 32'(flags), 32'b00100);

    // compare: no write, L and N set
    issue(4'd7, 1, 0, 0, 1'b1, 16'd3, st);
    issue(4'd7, 2, 0, 0, 1'b1, 16'd5, st);
    issue(4'd3, 0, 1, 2, 1'b0, 16'd0, st);
    idle(3);
    check("t5_flags", 32'(flags), 32'b00111);
    peek("t5_r1", 1, 16'd3);
    peek("t5_r2", 2, 16'd5);
    peek("t5_r0", 0, 16'd0);

    // shifts
    issue(4'd7, 1, 0, 0, 1'b1, 16'h0001, st);
    issue(4'd8, 2, 1, 0, 1'b1, 16'd4, st);
    issue(4'd8, 3, 1, 0, 1'b1, 16'hFFFF, st);
    idle(3);
    peek("t6_lsh_left", 2, 16'h0010);
    peek("t6_lsh_right", 3, 16'h0000);
    check("t6_flags", 32'(flags), 32'b10110);

    // reset while an instruction is in EX: dropped
    issue(4'd7, 5, 0, 0, 1'b1, 16'h1234, st);
    #2;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_ex_res_valid", 32'(res_valid), 32'd0);
    check("rst_ex_in_ready", 32'(in_ready), 32'd0);
    peek("rst_ex_r5", 5, 16'h0000);
    reset = 1'b1;
    idle(2);
    peek("rst_ex_r5_after", 5, 16'h0000);

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        rmax = ($urandom_range(0, 7) == 0) ? 15 : 3;
        op   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
        case ($urandom_range(0, 5))
          0: imm = 16'h0000;
          1: imm = 16'h0001;
          2: imm = 16'h8000;
          3: imm = 16'hFFFF;
          4: imm = 16'(int'($urandom_range(0, 40)) - 20);
          default: imm = 16'($urandom);
        endcase
        dst = int'($urandom_range(0, rmax));
        sa  = int'($urandom_range(0, rmax));
        sb  = int'($urandom_range(0, rmax));
        issue(op, dst, sa, sb, 1'($urandom_range(0, 1)), imm, st);
      end
    end
    idle(3);
    for (int r = 0; r < NR; r++) peek("final_reg", r, 16'(m_regs[r]));
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
